// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : stream_packer
// Brief    : Packs `ratio` consecutive `width`-bit beats into one wide word,
//            with early flush via in_last and a lane-valid keep mask. The
//            wide word sits in a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module stream_packer #(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [width-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    output logic [width*ratio-1:0]   out_data,
    output logic [ratio-1:0]         out_keep,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              word_count
);

    localparam int                 c_idx_w    = (ratio > 1) ? $clog2(ratio) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(ratio - 1);
    localparam logic [ratio-1:0]   c_one_hot0 = {{(ratio-1){1'b0}}, 1'b1};

    logic [c_idx_w-1:0]       idx_q,        idx_d;
    logic [width*ratio-1:0]   acc_q,        acc_d;
    logic [ratio-1:0]         kacc_q,       kacc_d;
    logic [width*ratio-1:0]   out_data_q,   out_data_d;
    logic [ratio-1:0]         out_keep_q,   out_keep_d;
    logic                     out_last_q,   out_last_d;
    logic                     out_valid_q,  out_valid_d;
    logic [15:0]              word_count_q, word_count_d;

    logic                     w_in_acc;
    logic                     w_out_acc;
    logic                     w_complete;
    logic [width*ratio-1:0]   w_acc_merged;
    logic [ratio-1:0]         w_keep_merged;

    // The output register can take a new word if empty or being drained now.
    assign in_ready  = !out_valid_q || out_ready;
    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = out_valid_q && out_ready;
    assign w_complete = w_in_acc && ((idx_q == c_last_idx) || in_last);

    // Accumulator and mask with the incoming beat merged into lane idx.
    always_comb begin
        w_acc_merged = acc_q;
        for (int i = 0; i < ratio; i++) begin
            if (idx_q == c_idx_w'(i)) begin
                w_acc_merged[i*width +: width] = in_data;
            end
        end
        w_keep_merged = kacc_q | (c_one_hot0 << idx_q);
    end

    // Next-state logic for the packer and the output register.
    always_comb begin
        idx_d        = idx_q;
        acc_d        = acc_q;
        kacc_d       = kacc_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;

        // Draining the word first; a completing word below overrides valid.
        if (w_out_acc) begin
            out_valid_d  = 1'b0;
            word_count_d = word_count_q + 16'd1;
        end

        if (w_in_acc) begin
            if (w_complete) begin
                out_data_d  = w_acc_merged;
                out_keep_d  = w_keep_merged;
                out_last_d  = in_last;
                out_valid_d = 1'b1;
                acc_d       = '0;
                kacc_d      = '0;
                idx_d       = '0;
            end else begin
                acc_d  = w_acc_merged;
                kacc_d = w_keep_merged;
                idx_d  = idx_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            acc_q        <= '0;
            kacc_q       <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            kacc_q       <= kacc_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_keep   = out_keep_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_packer
// Brief    : Directed self-checking bench for stream_packer (width 8, ratio 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;

    stream_packer #(.width(8), .ratio(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and take the edge.
    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        // Reset held two cycles with a valid beat offered.
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  32'h0);
        chk("rst_out_keep",  out_keep,  4'h0);
        chk("rst_out_last",  out_last,  1'b0);
        chk("rst_wc",        word_count, 16'h0);
        chk("rst_in_ready",  in_ready,  1'b1);
        reset = 1'b0;
        idle();
        tick();
        chk("rst_no_capture", out_valid, 1'b0);

        // Full word.
        beat(8'h44, 1'b0);
        beat(8'h54, 1'b0);
        beat(8'hAA, 1'b0);
        chk("full_not_yet", out_valid, 1'b0);
        beat(8'hBB, 1'b0);
        idle();
        chk("full_valid", out_valid, 1'b1);
        chk("full_data",  out_data,  32'hBBAA5444);
        chk("full_keep",  out_keep,  4'hF);
        chk("full_last",  out_last,  1'b0);
        tick();
        chk("full_valid_1cyc", out_valid, 1'b0);
        chk("full_wc",         word_count, 16'd1);
        chk("full_data_held",  out_data,  32'hBBAA5444);

        // Early flush, then next beat lands in lane 0.
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b1);
        chk("flush_valid", out_valid, 1'b1);
        chk("flush_data",  out_data,  32'h00002211);
        chk("flush_keep",  out_keep,  4'h3);
        chk("flush_last",  out_last,  1'b1);
        chk("flush_in_ready", in_ready, 1'b1);
        beat(8'h33, 1'b1);
        idle();
        chk("flush2_valid", out_valid, 1'b1);
        chk("flush2_data",  out_data,  32'h00000033);
        chk("flush2_keep",  out_keep,  4'h1);
        chk("flush2_wc",    word_count, 16'd2);
        tick();
        chk("flush2_drain", out_valid, 1'b0);
        chk("flush2_wc_after", word_count, 16'd3);

        // Backpressure.
        out_ready = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        in_valid = 1'b1; in_data = 8'h05; in_last = 1'b0;
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_valid",    out_valid, 1'b1);
            chk("bp_data",     out_data,  32'h04030201);
            chk("bp_keep",     out_keep,  4'hF);
            chk("bp_last",     out_last,  1'b0);
        end
        chk("bp_wc_frozen", word_count, 16'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_wc",    word_count, 16'd4);
        beat(8'h06, 1'b0);
        beat(8'h07, 1'b0);
        beat(8'h08, 1'b0);
        idle();
        chk("bp_next_data", out_data, 32'h08070605);
        chk("bp_next_keep", out_keep, 4'hF);
        tick();
        chk("bp_next_wc", word_count, 16'd5);

        // Back-to-back streaming of eight beats.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
            #1;
            chk("stream_in_ready", in_ready, 1'b1);
            tick();
            if (i == 4) begin
                chk("stream_w1_valid", out_valid, 1'b1);
                chk("stream_w1_data",  out_data,  32'h04030201);
            end
            if (i == 5) chk("stream_w1_gone", out_valid, 1'b0);
        end
        idle();
        chk("stream_w2_valid", out_valid, 1'b1);
        chk("stream_w2_data",  out_data,  32'h08070605);
        tick();
        chk("stream_wc", word_count, 16'd7);

        // Reset mid-word.
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
        tick();
        reset = 1'b0;
        idle();
        chk("mid_rst_wc",    word_count, 16'd0);
        chk("mid_rst_valid", out_valid,  1'b0);
        chk("mid_rst_ready", in_ready,   1'b1);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        idle();
        chk("mid_rst_data", out_data, 32'h04030201);
        chk("mid_rst_keep", out_keep, 4'hF);
        tick();
        chk("mid_rst_wc_after", word_count, 16'd1);

        // Counter wrap: one-beat flushes back to back, one handshake per cycle.
        in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("wrap_keep", out_keep, 4'h1);
        chk("wrap_data", out_data, 32'h0000005A);
        idle();
        tick();
        chk("wrap_ffff", word_count, 16'hFFFF);
        beat(8'h77, 1'b1);
        idle();
        chk("wrap_pending", word_count, 16'hFFFF);
        tick();
        chk("wrap_zero", word_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_packer.md
# stream_packer

Downstream width-conversion stage for the 8-bit valid/ready pipeline register stage. It consumes the register's `width`-bit output stream and packs `ratio` consecutive beats into one wide word. An optional early flush via `in_last` emits a partial word with a lane-valid mask. The wide word is held in an output register that exposes the same valid/ready handshake to the next stage.

## Interface
- `width`, default 8: bits per input beat (lane width).
- `ratio`, default 4: input beats per output word; ≥2; power of two not required.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: synchronous, active-high reset.
- `in_data`, input, `width` bits: input beat.
- `in_valid`, input, 1 bit: `in_data`/`in_last` valid.
- `in_ready`, output, 1 bit: stage can accept a beat this cycle.
- `in_last`, input, 1 bit: beat closes the current word early (flush).
- `out_data`, output, `width*ratio` bits: packed word; first accepted beat in bits [width-1:0].
- `out_keep`, output, `ratio` bits: bit i=1 ⇒ lane i holds a received beat.
- `out_last`, output, 1 bit: word was closed by `in_last`.
- `out_valid`, output, 1 bit: output word valid.
- `out_ready`, input, 1 bit: downstream accepts the word.
- `word_count`, output, 16 bits: number of completed output handshakes; wraps modulo 2^16.

## Operation
- Input accept: `in_valid && in_ready`. Output accept: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready` and registered `out_valid` only. It does not depend on `in_valid` or `in_last`.
- State:
  - lane index `idx` (0..ratio-1);
  - accumulator `acc` (`width*ratio` bits);
  - mask `kacc` (`ratio` bits);
  - output register (`out_data`, `out_keep`, `out_last`, `out_valid`);
  - `word_count`.
- On input accept:
  - write `in_data` into lane `idx` and set `kacc[idx]`.
  - If `idx == ratio-1` or `in_last` (word completes):
    - load `out_data` ← `acc` with the new lane merged;
    - load `out_keep` ← `kacc` with bit `idx` set;
    - load `out_last` ← `in_last`;
    - set `out_valid` ← 1;
    - clear `acc`, `kacc`, and `idx` to 0.
  - Otherwise `idx` increments.
- Lanes not written in a word are 0 in `out_data`.
- On output accept with no word completing in the same cycle, `out_valid` ← 0. `out_data`, `out_keep`, and `out_last` keep their last values.
- Simultaneous output accept and word completion: new word loads, `out_valid` stays 1, and `word_count` increments once.
- `word_count` increments on every output accept; FFFF+1 → 0000.
- While `out_valid && !out_ready`:
  - `out_data`, `out_keep`, and `out_last` must be held stable;
  - `in_ready` = 0, so no beat is accepted and the accumulator is frozen.
- `in_last` on lane `ratio-1` gives `out_keep` all ones and `out_last` = 1.
- `in_data` and `in_last` are ignored when `in_valid` = 0. `out_ready` is ignored when `out_valid` = 0.

## Timing
- Reset (synchronous, takes effect at the edge where `reset` = 1) clears:
  - `idx`, `acc`, `kacc`;
  - `out_data`, `out_keep`, `out_last`, `out_valid` (all 0);
  - `word_count` (0).
- During and after reset, `in_ready` = 1.
- Reset mid-word discards the partial accumulation and any pending output word. No beat is accepted on a reset cycle.
- Latency: a word-completing beat accepted at edge N gives `out_valid` = 1 immediately after edge N.
- Throughput: one beat per cycle when `out_ready` is held high. The output word is valid one cycle per `ratio` beats.
- No combinational path from `in_valid` to `in_ready`, or from any input to `out_*`.

## Test plan
- Reset check: hold `reset` 2 cycles with `in_valid` = 1 → all outputs 0, `word_count` = 0, `in_ready` = 1, no beat captured.
- Full word: beats 44, 54, AA, BB with `out_ready` = 1 → `out_data` = BBAA5444, `out_keep` = F, `out_last` = 0, `out_valid` high for exactly 1 cycle after the 4th accept, `word_count` = 1.
- Early flush: beats 11, then 22 with `in_last` → `out_data` = 00002211, `out_keep` = 3, `out_last` = 1. Next beat 33 lands in lane 0.
- Backpressure: complete word 04030201 with `out_ready` = 0 for 5 cycles and `in_valid` held 1 with 05 → `in_ready` = 0 and outputs stable throughout. After `out_ready` = 1, 05 is accepted in that same cycle into lane 0.
- Streaming: beats 01..08 back-to-back with `out_ready` = 1 → words 04030201 then 08070605, `word_count` = 2, `in_ready` never low.
- Reset mid-word: 2 beats AA, BB, then reset 1 cycle, then beats 01..04 → single word 04030201 with `out_keep` = F. Separately, preload `word_count` to FFFF via handshakes and complete one more → 0000.
